// File: rtl/simon_control_if.sv
// Controller <-> datapath link for the Simon game: strobes and mode selects one way, status flags the other.
interface simon_control_if;
  logic dp_reset;
  logic count_ns;
  logic count_i;
  logic rst_i;
  logic m1;
  logic m2;
  logic m3;
  logic m4;
  logic legal;
  logic right_guess;
  logic i_eq_ns;

  modport master (
    output dp_reset, count_ns, count_i, rst_i, m1, m2, m3, m4,
    input  legal, right_guess, i_eq_ns
  );

  modport slave (
    input  dp_reset, count_ns, count_i, rst_i, m1, m2, m3, m4,
    output legal, right_guess, i_eq_ns
  );
endinterface

// File: rtl/simon_control.sv
// Simon game controller: INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE) with Mealy datapath strobes.
// Optional auto-advancing playback timer enabled by defining SIMON_PLAYBACK_TIMER_EN.
module simon_control #(
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned PLAYBACK_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next,
  simon_control_if.master        dp,
  output logic                   win,
  output logic                   lose
);

  localparam int unsigned RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("simon_control: DEPTH must be at least 2");
  end
  if (PLAYBACK_CYCLES == 0) begin : g_bad_cycles
    $error("simon_control: PLAYBACK_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_d;
  logic          next_q;
  logic          press;
  logic          advance;
  logic [RW-1:0] rounds;
  logic          cns;
  logic          ci;
  logic          ri;
  logic          set_win;
  logic          set_lose;

  assign press = next & ~next_q;

`ifdef SIMON_PLAYBACK_TIMER_EN
  localparam int unsigned TW = (PLAYBACK_CYCLES > 1) ? $clog2(PLAYBACK_CYCLES) : 1;

  logic [TW-1:0] timer;
  logic          timer_run;

  assign timer_run = (state == S_PLAYBACK) || (state == S_DONE);
  assign advance   = (timer == '0);

  // Countdown restarts on any state change so each phase starts with a full display period.
  always_ff @(posedge clk) begin
    if (reset || (state_d != state) || !timer_run || (timer == '0)) begin
      timer <= TW'(PLAYBACK_CYCLES - 1);
    end else begin
      timer <= timer - TW'(1);
    end
  end
`else
  assign advance = press;
`endif

  // Next-state and Mealy strobe decode; strobes fire in the decision cycle.
  always_comb begin
    state_d  = state;
    cns      = 1'b0;
    ci       = 1'b0;
    ri       = 1'b0;
    set_win  = 1'b0;
    set_lose = 1'b0;
    case (state)
      S_INPUT: begin
        if (press && dp.legal) begin
          cns     = 1'b1;
          ri      = 1'b1;
          state_d = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        if (dp.i_eq_ns) begin
          ri      = 1'b1;
          state_d = S_REPEAT;
        end else if (advance) begin
          ci = 1'b1;
        end
      end
      S_REPEAT: begin
        if (dp.i_eq_ns && (rounds == RW'(DEPTH - 1))) begin
          ri      = 1'b1;
          set_win = 1'b1;
          state_d = S_DONE;
        end else if (dp.i_eq_ns) begin
          state_d = S_INPUT;
        end else if (press && !dp.right_guess) begin
          ri       = 1'b1;
          set_lose = 1'b1;
          state_d  = S_DONE;
        end else if (press) begin
          ci = 1'b1;
        end
      end
      S_DONE: begin
        if (dp.i_eq_ns) begin
          ri = 1'b1;
        end else if (advance) begin
          ci = 1'b1;
        end
      end
    endcase
    if (reset) begin
      cns      = 1'b0;
      ci       = 1'b0;
      ri       = 1'b0;
      set_win  = 1'b0;
      set_lose = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_INPUT;
      next_q <= 1'b0;
      rounds <= '0;
      win    <= 1'b0;
      lose   <= 1'b0;
    end else begin
      state  <= state_d;
      next_q <= next;
      if (cns)      rounds <= rounds + RW'(1);
      if (set_win)  win    <= 1'b1;
      if (set_lose) lose   <= 1'b1;
    end
  end

  assign dp.dp_reset = reset;
  assign dp.count_ns = cns;
  assign dp.count_i  = ci;
  assign dp.rst_i    = ri;
  assign dp.m1       = (state == S_INPUT);
  assign dp.m2       = (state == S_PLAYBACK);
  assign dp.m3       = (state == S_REPEAT);
  assign dp.m4       = (state == S_DONE);

endmodule

// File: doc/simon_control.md
# simon_control

Control unit for the Simon game. Sequences the Simon datapath through pattern entry, playback, player repeat and game-over phases. Detects button presses and issues the one-cycle datapath strobes (`count_ns`, `count_i`, `rst_i`) plus the one-hot mode selects (`m1`–`m4`). Consumes the datapath status flags (`legal`, `right_guess`, `i_eq_ns`) and instantiates beside the datapath in the Simon top level.

## Interface
- `DEPTH`, 64: pattern memory entries; the controller caps stored entries at DEPTH-1.
- `PLAYBACK_CYCLES`, 50000000: display cycles per playback element; used only with the macro in Configuration.
- `clk  input  1  clock`
- `reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high`
- `next  input  1  player button, synchronous level; a press is a 0→1 transition`
- `legal  input  1  current switch pattern is allowed`
- `right_guess  input  1  switch pattern equals the memory word at index i`
- `i_eq_ns  input  1  datapath index equals the stored-entry count`
- `dp_reset  output  1  datapath reset; equals `reset` combinationally`
- `count_ns  output  1  strobe: store the pattern and increment ns`
- `count_i  output  1  strobe: increment i`
- `rst_i  output  1  strobe: clear i`
- `m1, m2, m3, m4  output  1 each  one-hot mode: INPUT, PLAYBACK, REPEAT, DONE`
- `win  output  1  sticky; game ended with the memory full`
- `lose  output  1  sticky; game ended on a wrong guess`

## Operation
- The state register is 2 bits: INPUT=0, PLAYBACK=1, REPEAT=2, DONE=3.
  - `m1`–`m4` are a Moore decode of the state register.
  - Strobes are Mealy outputs, asserted in the cycle of the decision, so the datapath updates on the same edge as the state change.
- Press detection: `press = next & ~next_q`, where `next_q` is `next` registered. A held button produces exactly one press.
- `rounds` is an internal counter of width clog2(DEPTH), incremented with every `count_ns`.
- INPUT:
  - On press with `legal`=1: assert `count_ns` and `rst_i`, then go to PLAYBACK.
  - On press with `legal`=0: no strobes; stay in INPUT.
- PLAYBACK:
  - If `i_eq_ns`: assert `rst_i` and go to REPEAT. This has priority over any advance in the same cycle.
  - Otherwise, advance with `count_i` (see Configuration).
- REPEAT, evaluated in priority order:
  - If `i_eq_ns` and `rounds`==DEPTH-1: assert `rst_i`, set `win`, go to DONE.
  - Else if `i_eq_ns`: go to INPUT with no strobe.
  - Else on press with `right_guess`=0: assert `rst_i`, set `lose`, go to DONE.
  - Else on press with `right_guess`=1: assert `count_i`.
- DONE:
  - Loops the stored sequence. If `i_eq_ns`: assert `rst_i`. Otherwise advance as in PLAYBACK.
  - Exit only through `reset`.
- `count_i` and `rst_i` are never asserted in the same cycle. `count_ns` is asserted only in INPUT.

## Timing
- Reset values: state=INPUT, `m1`=1, `m2`–`m4`=0, `count_ns`=`count_i`=`rst_i`=0, `win`=`lose`=0, `rounds`=0, `next_q`=0, playback timer=PLAYBACK_CYCLES-1.
- `dp_reset`=1 in every cycle that `reset`=1. All strobes are forced to 0 while `reset`=1.
- Press-to-strobe latency is 0 cycles: the strobe is asserted in the cycle `next` first reads 1.
- The state change is visible one edge later.
- After the final correct guess in REPEAT:
  - cycle N: `count_i`;
  - cycle N+1: `i_eq_ns`=1 and the REPEAT exit is decided;
  - cycle N+2: the next state (INPUT or DONE) is visible.
- Reset mid-operation (any state, any timer value) returns everything to the reset values on the next edge.

## Configuration
- `SIMON_PLAYBACK_TIMER_EN` defined:
  - PLAYBACK and DONE advance automatically. The timer counts down from PLAYBACK_CYCLES-1; at 0 it asserts `count_i` and reloads.
  - The timer reloads on every state entry.
  - `next` is ignored in PLAYBACK and DONE.
- `SIMON_PLAYBACK_TIMER_EN` undefined:
  - PLAYBACK and DONE advance one element per press.
  - No timer logic is present and PLAYBACK_CYCLES is unused.

## Test plan
- Reset, then press with `legal`=1 → one cycle of `count_ns`=`rst_i`=1; `m2`=1 on the following edge; `rounds`=1.
- INPUT, press with `legal`=0 → no strobes, `m1` stays 1. Hold `next` high for 10 cycles with `legal`=1 → exactly one `count_ns`.
- Timer off, one stored entry: press in PLAYBACK → `count_i`. Drive `i_eq_ns`=1 → `rst_i` and REPEAT. Press with `right_guess`=1 → `count_i`, then back to INPUT once `i_eq_ns`=1.
- REPEAT, press with `right_guess`=0 → `rst_i`, `lose`=1, `m4`=1. `lose` stays 1 for 20 presses until `reset`.
- DEPTH=4: three correct rounds, `i_eq_ns`=1 in REPEAT with `rounds`=3 → `win`=1, DONE.
- Timer on, PLAYBACK_CYCLES=5 → `count_i` every 5th cycle in PLAYBACK. Assert `reset` mid-count → state INPUT, `dp_reset`=1, timer reloaded to 4.
